dsp_result_capture: RTL and testbench

- Receive side of the DSP slice datapath: collects the products and chain sums the slice produces for each issued operation and buffers them for downstream logic.
- Runs a latency-matched tag pipeline alongside the slice, so each result leaves tagged with the operation that produced it.
- Presents results on a ready/valid first-word-fall-through (FWFT) queue, counting any result lost to backpressure.
- Sits directly on the slice's resulta/resultb/chainout outputs, sharing its clock and enable.

---
 rtl/dsp_result_capture.sv | 150 +++++++++++++++
 tb/tb_dsp_result_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_result_capture.sv
// Receive side of the DSP slice: a latency-matched tag pipeline marks which enabled
// edges carry a valid slice result, and captured results drain through a FWFT queue.
module dsp_result_capture #(
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       enable,
  input  logic                       issue,
  input  logic [1:0]                 issue_func,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [36:0]                resulta,
  input  logic [36:0]                resultb,
  input  logic [63:0]                chainout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [73:0]                out_data,
  output logic                       out_chain,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic             chain;
    logic [TAG_W-1:0] tag;
    logic [73:0]      data;
  } entry_t;

  // Tag pipeline: one {vld, chain, tag} per enabled cycle of slice latency.
  logic [LAT-1:0]            vld_q;
  logic [LAT-1:0]            chain_q;
  logic [LAT-1:0][TAG_W-1:0] tag_q;

  // Only bit 1 of the func code matters on the receive side.
  logic unused_func;
  assign unused_func = issue_func[0];

  // NOTE: sequential state is always assigned with <= so every register samples
  // pre-edge values; a blocking = here would collapse the pipeline into one stage.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= '0;
    end else if (enable) begin
      for (int i = LAT - 1; i > 0; i--) vld_q[i] <= vld_q[i-1];
      vld_q[0] <= issue;
    end
  end

  // Chain/tag travel with vld but need no reset: they are ignored while vld is 0.
  always_ff @(posedge clk) begin
    if (enable) begin
      for (int i = LAT - 1; i > 0; i--) begin
        chain_q[i] <= chain_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
      chain_q[0] <= issue_func[1];
      tag_q[0]   <= issue_tag;
    end
  end

  // Capture and queue control.
  logic             capture;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;
  entry_t           wr_entry;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  entry_t           mem_q [DEPTH];

  assign capture = enable & vld_q[LAT-1];
  assign pop     = out_valid & out_ready;
  assign full    = (count_q == FULL_CNT);
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  always_comb begin
    wr_entry.chain = chain_q[LAT-1];
    wr_entry.tag   = tag_q[LAT-1];
    if (chain_q[LAT-1]) wr_entry.data = {{10{chainout[63]}}, chainout};
    else                wr_entry.data = {resulta, resultb};
  end

  // NOTE: every always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read after
  // it was written, and zero outputs after reset come from masking with out_valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wr_entry;
  end

  entry_t head;
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head.data  : '0;
  assign out_chain = out_valid ? head.chain : 1'b0;
  assign out_tag   = out_valid ? head.tag   : '0;
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsp_result_capture.sv
// Directed bench for dsp_result_capture: stimulus pushes expected entries into a
// scoreboard queue, a negedge monitor compares every entry the DUT hands out.
module tb_dsp_result_capture;

  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic             chain;
    logic [TAG_W-1:0] tag;
    logic [73:0]      data;
  } exp_t;

  logic              clk = 1'b0;
  logic              clr, enable, issue, out_ready;
  logic [1:0]        issue_func;
  logic [TAG_W-1:0]  issue_tag;
  logic [36:0]       resulta, resultb;
  logic [63:0]       chainout;
  logic              out_valid, out_chain, overflow;
  logic [73:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        count;
  logic [7:0]        drop_cnt;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dsp_result_capture #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .clr(clr), .enable(enable), .issue(issue),
    .issue_func(issue_func), .issue_tag(issue_tag),
    .resulta(resulta), .resultb(resultb), .chainout(chainout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chain(out_chain), .out_tag(out_tag), .count(count),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue = 1'b0; issue_func = 2'b00; issue_tag = '0;
  endtask

  // Handshake state is stable from the negedge through the next rising edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_tag=%0h expected=none", out_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("head_tag",   128'(out_tag),   128'(e.tag));
        check("head_chain", 128'(out_chain), 128'(e.chain));
        check("head_data",  128'(out_data),  128'(e.data));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    128'(out_valid), 128'(0));
    check({tag, "_count"},    128'(count),     128'(0));
    check({tag, "_drop_cnt"}, 128'(drop_cnt),  128'(0));
    check({tag, "_overflow"}, 128'(overflow),  128'(0));
    check({tag, "_data"},     128'(out_data),  128'(0));
    check({tag, "_tag"},      128'(out_tag),   128'(0));
    check({tag, "_chain"},    128'(out_chain), 128'(0));
  endtask

  initial begin
    clr = 1'b1; enable = 1'b1; out_ready = 1'b0;
    idle_inputs();
    resulta = '0; resultb = '0; chainout = '0;
    #1;
    cyc(); cyc();
    clr = 1'b0;
    check_all_zero("reset");

    // Independent mode, tag 1.
    out_ready = 1'b1;
    issue = 1'b1; issue_func = 2'b00; issue_tag = 4'd1;
    exp_q.push_back('{chain: 1'b0, tag: 4'd1, data: {37'h6, 37'h1E}});
    cyc();                                   // edge 0
    idle_inputs();
    resulta = 37'h6; resultb = 37'h1E;
    cyc(); check("indep_lat_e1", 128'(out_valid), 128'(0));
    cyc(); check("indep_lat_e2", 128'(out_valid), 128'(0));
    cyc(); check("indep_lat_e3", 128'(out_valid), 128'(1));
    cyc(); cyc();
    check("indep_drained", 128'(count), 128'(0));

    // Chained mode, tag 2: negative chainout sign-extends.
    issue = 1'b1; issue_func = 2'b11; issue_tag = 4'd2;
    exp_q.push_back('{chain: 1'b1, tag: 4'd2, data: {{70{1'b1}}, 4'h0}});
    cyc();
    idle_inputs();
    resulta = 37'h1_2345_6789; resultb = 37'h0_ABCD_EF01;
    chainout = 64'hFFFF_FFFF_FFFF_FFF0;
    cyc(); cyc(); cyc();
    check("chain_valid", 128'(out_valid), 128'(1));
    cyc(); cyc();

    // Enable stall: two disabled edges stretch capture from edge 3 to edge 5.
    issue = 1'b1; issue_func = 2'b01; issue_tag = 4'd3;
    exp_q.push_back('{chain: 1'b0, tag: 4'd3, data: {37'h123, 37'h456}});
    cyc();                                   // edge 0
    idle_inputs();
    resulta = 37'h123; resultb = 37'h456;
    enable = 1'b0;
    cyc(); check("stall_e1", 128'(out_valid), 128'(0));
    cyc(); check("stall_e2", 128'(out_valid), 128'(0));
    enable = 1'b1;
    cyc(); check("stall_e3", 128'(out_valid), 128'(0));
    cyc(); check("stall_e4", 128'(out_valid), 128'(0));
    cyc(); check("stall_e5", 128'(out_valid), 128'(1));
    cyc(); cyc();

    // Overflow: 10 back-to-back issues into a blocked queue; tags 8,9 are dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      issue     = (i < 10);
      issue_tag = TAG_W'(i);
      issue_func = 2'b00;
      if (i < 8)
        exp_q.push_back('{chain: 1'b0, tag: TAG_W'(i), data: {37'(i + 16), 37'(i + 32)}});
      resulta = (i >= 3) ? 37'(i - 3 + 16) : 37'h0;
      resultb = (i >= 3) ? 37'(i - 3 + 32) : 37'h0;
      cyc();
    end
    idle_inputs();
    check("ovf_count",    128'(count),    128'(8));
    check("ovf_drop_cnt", 128'(drop_cnt), 128'(2));
    check("ovf_flag",     128'(overflow), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("ovf_drained",     128'(count),    128'(0));
    check("ovf_sticky",      128'(overflow), 128'(1));
    check("ovf_drop_stable", 128'(drop_cnt), 128'(2));

    // Full with pop: 9th capture lands on a full queue while the head is popped.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      issue     = (i < 9);
      issue_tag = TAG_W'(i);
      issue_func = 2'b00;
      if (i < 9)
        exp_q.push_back('{chain: 1'b0, tag: TAG_W'(i), data: {37'(i + 64), 37'(i + 96)}});
      resulta = (i >= 3) ? 37'(i - 3 + 64) : 37'h0;
      resultb = (i >= 3) ? 37'(i - 3 + 96) : 37'h0;
      cyc();
    end
    idle_inputs();
    check("fullpop_pre_count", 128'(count), 128'(8));
    resulta = 37'(8 + 64); resultb = 37'(8 + 96);
    out_ready = 1'b1;
    cyc();                                   // capture of tag 8 with a pop
    check("fullpop_count", 128'(count),    128'(8));
    check("fullpop_drop",  128'(drop_cnt), 128'(2));
    for (int i = 0; i < 10; i++) cyc();
    check("fullpop_drained", 128'(count), 128'(0));

    // Reset mid-flight: both in-flight operations are discarded.
    issue = 1'b1; issue_tag = 4'd5;
    resulta = 37'h55; resultb = 37'h66;
    cyc();                                   // edge 0
    issue_tag = 4'd6;
    cyc();                                   // edge 1
    idle_inputs();
    clr = 1'b1;
    cyc();                                   // edge 2
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("midrst_no_valid", 128'(out_valid), 128'(0));
    end
    check_all_zero("midrst");

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
